pwr_seq_ctrl: RTL and testbench

PWR_SEQ_CTRL -- requirements
Module: pwr_seq_ctrl

---
 rtl/e_gpu_pwr_pkg.sv | 22 ++
 rtl/cu_pwr_fsm.sv | 82 ++++++++
 rtl/pwr_seq_ctrl.sv | 115 +++++++++++
 tb/tb_pwr_seq_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/e_gpu_pwr_pkg.sv
// rtl/e_gpu_pwr_pkg.sv - shared state encodings and default parameters for the GPU power sequencer
package e_gpu_pwr_pkg;

    localparam int DEF_NUM_CU     = 4;
    localparam int DEF_RST_CYCLES = 4;
    localparam int DEF_DLY_W      = 8;

    typedef enum logic [1:0] {
        TOP_IDLE   = 2'd0,
        TOP_L2_RST = 2'd1,
        TOP_CU_RUN = 2'd2,
        TOP_L2_OFF = 2'd3
    } top_state_e;

    typedef enum logic [1:0] {
        CU_OFF    = 2'd0,
        CU_RST    = 2'd1,
        CU_ACTIVE = 2'd2,
        CU_DRAIN  = 2'd3
    } cu_state_e;

endpackage

// File: rtl/cu_pwr_fsm.sv
// rtl/cu_pwr_fsm.sv - per compute-unit power FSM with reset-hold and sleep-drain counters
module cu_pwr_fsm
    import e_gpu_pwr_pkg::*;
#(
    parameter int RST_CYCLES = DEF_RST_CYCLES,
    parameter int DLY_W      = DEF_DLY_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             go_i,
    input  logic [DLY_W-1:0] sleep_dly_i,
    input  logic             sleep_req_i,
    input  logic             delay_sleep_i,
    output logic             clk_en_o,
    output logic             rst_n_o,
    output logic             off_o
);

    localparam int              RC_W     = $clog2(RST_CYCLES + 1);
    localparam logic [RC_W-1:0] RST_LOAD = RC_W'(RST_CYCLES - 1);

    cu_state_e        state;
    logic [RC_W-1:0]  rst_cnt;
    logic [DLY_W-1:0] drain_cnt;

    // CU lifecycle: a launch pulse wakes an OFF unit; once drained back to OFF it stays there
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= CU_OFF;
            rst_cnt   <= '0;
            drain_cnt <= '0;
            clk_en_o  <= 1'b0;
            rst_n_o   <= 1'b0;
        end else begin
            case (state)
                CU_OFF: begin
                    if (go_i) begin
                        state    <= CU_RST;
                        rst_cnt  <= RST_LOAD;
                        clk_en_o <= 1'b1;
                        rst_n_o  <= 1'b0;
                    end
                end
                CU_RST: begin
                    if (rst_cnt == '0) begin
                        state   <= CU_ACTIVE;
                        rst_n_o <= 1'b1;
                    end else begin
                        rst_cnt <= rst_cnt - RC_W'(1);
                    end
                end
                CU_ACTIVE: begin
                    if (sleep_req_i && !delay_sleep_i) begin
                        state     <= CU_DRAIN;
                        drain_cnt <= sleep_dly_i;
                    end
                end
                CU_DRAIN: begin
                    // A veto or a withdrawn request abandons the drain; the delay wins a tie
                    if (delay_sleep_i || !sleep_req_i) begin
                        state     <= CU_ACTIVE;
                        drain_cnt <= '0;
                    end else if (drain_cnt == '0) begin
                        state    <= CU_OFF;
                        clk_en_o <= 1'b0;
                        rst_n_o  <= 1'b0;
                    end else begin
                        drain_cnt <= drain_cnt - DLY_W'(1);
                    end
                end
                default: begin
                    state    <= CU_OFF;
                    clk_en_o <= 1'b0;
                    rst_n_o  <= 1'b0;
                end
            endcase
        end
    end

    assign off_o = (state == CU_OFF);

endmodule

// File: rtl/pwr_seq_ctrl.sv
// rtl/pwr_seq_ctrl.sv - launch sequencer: L2 reset, compute-unit wake/drain, L2 gating
module pwr_seq_ctrl
    import e_gpu_pwr_pkg::*;
#(
    parameter int NUM_CU     = DEF_NUM_CU,
    parameter int RST_CYCLES = DEF_RST_CYCLES,
    parameter int DLY_W      = DEF_DLY_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [NUM_CU-1:0] cu_mask_i,
    input  logic [DLY_W-1:0]  sleep_dly_i,
    input  logic [NUM_CU-1:0] cu_sleep_req_i,
    input  logic [NUM_CU-1:0] cu_delay_sleep_i,
    output logic [NUM_CU-1:0] cu_clk_en_o,
    output logic [NUM_CU-1:0] cu_rst_n_o,
    output logic              l2_clk_en_o,
    output logic              l2_rst_n_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int              RC_W     = $clog2(RST_CYCLES + 1);
    localparam logic [RC_W-1:0] RST_LOAD = RC_W'(RST_CYCLES - 1);

    top_state_e        state;
    logic [RC_W-1:0]   rst_cnt;
    logic [NUM_CU-1:0] mask_q;
    logic [DLY_W-1:0]  dly_q;
    logic [NUM_CU-1:0] cu_off;
    logic              cu_go;

    // Masked CUs leave OFF on the same edge that L2 leaves reset, so both start together
    assign cu_go = (state == TOP_L2_RST) && (rst_cnt == '0);

    // Launch sequencing; a start while busy is simply dropped
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= TOP_IDLE;
            rst_cnt     <= '0;
            mask_q      <= '0;
            dly_q       <= '0;
            l2_clk_en_o <= 1'b0;
            l2_rst_n_o  <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                TOP_IDLE: begin
                    if (start_i) begin
                        mask_q <= cu_mask_i;
                        dly_q  <= sleep_dly_i;
                        busy_o <= 1'b1;
                        if (cu_mask_i == '0) begin
                            state  <= TOP_L2_OFF;
                            done_o <= 1'b1;
                        end else begin
                            state       <= TOP_L2_RST;
                            rst_cnt     <= RST_LOAD;
                            l2_clk_en_o <= 1'b1;
                            l2_rst_n_o  <= 1'b0;
                        end
                    end
                end
                TOP_L2_RST: begin
                    if (rst_cnt == '0) begin
                        state      <= TOP_CU_RUN;
                        l2_rst_n_o <= 1'b1;
                    end else begin
                        rst_cnt <= rst_cnt - RC_W'(1);
                    end
                end
                TOP_CU_RUN: begin
                    // Unmasked CUs never leave OFF, so all-off means every masked CU finished
                    if (&cu_off) begin
                        state       <= TOP_L2_OFF;
                        l2_clk_en_o <= 1'b0;
                        l2_rst_n_o  <= 1'b0;
                        done_o      <= 1'b1;
                    end
                end
                TOP_L2_OFF: begin
                    state  <= TOP_IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state       <= TOP_IDLE;
                    l2_clk_en_o <= 1'b0;
                    l2_rst_n_o  <= 1'b0;
                    busy_o      <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_CU; g++) begin : g_cu
        cu_pwr_fsm #(
            .RST_CYCLES (RST_CYCLES),
            .DLY_W      (DLY_W)
        ) u_cu_pwr_fsm (
            .clk_i         (clk_i),
            .rst_ni        (rst_ni),
            .go_i          (cu_go & mask_q[g]),
            .sleep_dly_i   (dly_q),
            .sleep_req_i   (cu_sleep_req_i[g]),
            .delay_sleep_i (cu_delay_sleep_i[g]),
            .clk_en_o      (cu_clk_en_o[g]),
            .rst_n_o       (cu_rst_n_o[g]),
            .off_o         (cu_off[g])
        );
    end

endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// tb/tb_pwr_seq_ctrl.sv - directed self-checking bench for pwr_seq_ctrl
module tb_pwr_seq_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] cu_mask;
    logic [7:0] sleep_dly;
    logic [3:0] cu_sleep_req;
    logic [3:0] cu_delay_sleep;
    logic [3:0] cu_clk_en;
    logic [3:0] cu_rst_n;
    logic       l2_clk_en;
    logic       l2_rst_n;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int sb[$];
    int t0;

    pwr_seq_ctrl #(
        .NUM_CU     (4),
        .RST_CYCLES (4),
        .DLY_W      (8)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .start_i          (start),
        .cu_mask_i        (cu_mask),
        .sleep_dly_i      (sleep_dly),
        .cu_sleep_req_i   (cu_sleep_req),
        .cu_delay_sleep_i (cu_delay_sleep),
        .cu_clk_en_o      (cu_clk_en),
        .cu_rst_n_o       (cu_rst_n),
        .l2_clk_en_o      (l2_clk_en),
        .l2_rst_n_o       (l2_rst_n),
        .busy_o           (busy),
        .done_o           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Every done pulse must match the cycle the scoreboard predicted when the launch was driven
    always @(negedge clk) begin
        if (done === 1'b1) begin
            int exp_c;
            exp_c = (sb.size() != 0) ? sb.pop_front() : -1;
            chk("done_cycle", cyc, exp_c);
        end
    end

    initial begin
        rst_n          = 1'b0;
        start          = 1'b0;
        cu_mask        = 4'b0;
        sleep_dly      = 8'd0;
        cu_sleep_req   = 4'b0;
        cu_delay_sleep = 4'b0;
        #2;
        chk("rst_cu_clk_en", cu_clk_en, 4'b0);
        chk("rst_cu_rst_n", cu_rst_n, 4'b0);
        chk("rst_l2", {l2_clk_en, l2_rst_n}, 2'b00);
        chk("rst_busy_done", {busy, done}, 2'b00);
        tick();
        rst_n = 1'b1;
        tick();

        // Launch mask 0101: L2 reset hold, CU reset hold, busy start ignored
        start = 1'b1; cu_mask = 4'b0101; sleep_dly = 8'd3;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("l2_rst_hold", {l2_clk_en, l2_rst_n}, 2'b10);
            chk("l2_rst_cu_off", cu_clk_en, 4'b0);
            chk("l2_rst_busy", busy, 1'b1);
            if (i == 1) begin
                start = 1'b1; cu_mask = 4'b1111; sleep_dly = 8'd0;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            chk("cu_rst_l2_rel", {l2_clk_en, l2_rst_n}, 2'b11);
            chk("cu_rst_clk_en", cu_clk_en, 4'b0101);
            chk("cu_rst_rst_n", cu_rst_n, 4'b0000);
            tick();
        end
        chk("cu_active_rst_n", cu_rst_n, 4'b0101);
        chk("cu_active_clk_en", cu_clk_en, 4'b0101);

        // CU2 drain vetoed at count 1, then a full fresh drain
        cu_sleep_req = 4'b0100;
        tick(); tick(); tick();
        chk("cu2_drain_cnt1", cu_clk_en, 4'b0101);
        cu_delay_sleep = 4'b0100;
        tick();
        cu_delay_sleep = 4'b0000;
        chk("cu2_vetoed", cu_clk_en, 4'b0101);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("cu2_redrain", cu_clk_en, 4'b0101);
        end
        tick();
        chk("cu2_off", cu_clk_en, 4'b0001);

        // CU0 drains with delay 3: gated 4 cycles after drain entry, then done and L2 gated
        cu_sleep_req = 4'b0101;
        t0 = cyc;
        sb.push_back(t0 + 6);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("cu0_drain", cu_clk_en, 4'b0001);
        end
        tick();
        chk("cu0_off", cu_clk_en, 4'b0000);
        chk("cu0_off_l2_on", l2_clk_en, 1'b1);
        chk("cu0_off_no_done", done, 1'b0);
        tick();
        chk("l2_off_done", done, 1'b1);
        chk("l2_off_gated", {l2_clk_en, l2_rst_n}, 2'b00);
        chk("l2_off_busy", busy, 1'b1);
        cu_sleep_req = 4'b0000;
        tick();
        chk("post_done", {busy, done}, 2'b00);

        // Empty mask: done next cycle, L2 never enabled, start during busy dropped
        start = 1'b1; cu_mask = 4'b0000; sleep_dly = 8'd5;
        sb.push_back(cyc + 1);
        tick();
        chk("m0_done", done, 1'b1);
        chk("m0_l2", l2_clk_en, 1'b0);
        chk("m0_busy", busy, 1'b1);
        start = 1'b1; cu_mask = 4'b1111;
        tick();
        start = 1'b0;
        chk("m0_idle", {busy, done}, 2'b00);
        chk("m0_l2_after", l2_clk_en, 1'b0);
        chk("m0_cu_off", cu_clk_en, 4'b0000);
        tick();
        chk("m0_ignored", {busy, l2_clk_en}, 2'b00);

        // Async reset with CU0/CU1 active aborts everything without done
        start = 1'b1; cu_mask = 4'b0011; sleep_dly = 8'd2;
        tick();
        start = 1'b0;
        repeat (8) tick();
        chk("ab_active", {cu_clk_en, cu_rst_n}, 8'b0011_0011);
        chk("ab_busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("ab_cu", {cu_clk_en, cu_rst_n}, 8'b0);
        chk("ab_l2", {l2_clk_en, l2_rst_n}, 2'b00);
        chk("ab_busy_done", {busy, done}, 2'b00);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Normal launch after abort: CU3 with zero drain delay
        start = 1'b1; cu_mask = 4'b1000; sleep_dly = 8'd0;
        t0 = cyc;
        tick();
        start = 1'b0;
        chk("re_l2_rst", {l2_clk_en, l2_rst_n}, 2'b10);
        repeat (8) tick();
        chk("re_active", {cu_clk_en, cu_rst_n}, 8'b1000_1000);
        cu_sleep_req = 4'b1000;
        sb.push_back(t0 + 12);
        tick();
        chk("re_drain0", cu_clk_en, 4'b1000);
        tick();
        chk("re_off", cu_clk_en, 4'b0000);
        tick();
        chk("re_done", done, 1'b1);
        cu_sleep_req = 4'b0000;
        tick();
        chk("re_idle", busy, 1'b0);

        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
